// File: rtl/decorder_pkg.sv
// Shared constants for the V850 instruction-decode stage: execute-unit
// select codes, 6-bit opcode values, PSW flag positions and the registered
// ID/EX payload type.
package decorder_pkg;

  // Execute-unit select codes driven on circuit_sel_o.
  typedef enum logic [9:0] {
    SEL_NOP         = 10'd0,
    SEL_ADD         = 10'd1,
    SEL_SUB         = 10'd2,
    SEL_SUBR        = 10'd3,
    SEL_AND         = 10'd4,
    SEL_OR          = 10'd5,
    SEL_XOR         = 10'd6,
    SEL_CMP         = 10'd7,
    SEL_TST         = 10'd8,
    SEL_MOV         = 10'd9,
    SEL_BCOND_TAKEN = 10'd10
  } circuit_sel_t;

  // Operand routing chosen by the opcode.
  typedef enum logic [2:0] {
    FMT_NONE,   // NOP / unrecognised: everything zero
    FMT_I,      // reg-reg
    FMT_II,     // imm5 sign-extended into operand A
    FMT_VI_S,   // 32-bit, imm16 sign-extended
    FMT_VI_Z,   // 32-bit, imm16 zero-extended
    FMT_III     // conditional branch
  } fmt_t;

  // Format I (reg-reg)
  localparam logic [5:0] OP_MOV_R  = 6'b000000;
  localparam logic [5:0] OP_OR_R   = 6'b001000;
  localparam logic [5:0] OP_XOR_R  = 6'b001001;
  localparam logic [5:0] OP_AND_R  = 6'b001010;
  localparam logic [5:0] OP_TST_R  = 6'b001011;
  localparam logic [5:0] OP_SUBR_R = 6'b001100;
  localparam logic [5:0] OP_SUB_R  = 6'b001101;
  localparam logic [5:0] OP_ADD_R  = 6'b001110;
  localparam logic [5:0] OP_CMP_R  = 6'b001111;
  // Format II (imm5)
  localparam logic [5:0] OP_MOV_I  = 6'b010000;
  localparam logic [5:0] OP_ADD_I  = 6'b010010;
  localparam logic [5:0] OP_CMP_I  = 6'b010011;
  // Format VI (imm16, 32-bit)
  localparam logic [5:0] OP_ADDI   = 6'b110000;
  localparam logic [5:0] OP_MOVEA  = 6'b110001;
  localparam logic [5:0] OP_ORI    = 6'b110100;
  localparam logic [5:0] OP_XORI   = 6'b110101;
  localparam logic [5:0] OP_ANDI   = 6'b110110;
  // Format III: opcode[5:2] identifies Bcond, opcode[1:0] carry displacement
  localparam logic [3:0] OP_BCOND_HI = 4'b1011;

  // PSW flag positions
  localparam int PSW_Z  = 0;
  localparam int PSW_S  = 1;
  localparam int PSW_OV = 2;
  localparam int PSW_CY = 3;

  // Everything the ID stage hands to EX.
  typedef struct packed {
    logic [31:0]  reg1;
    logic [31:0]  reg2;
    logic [31:0]  reg3;
    logic         increment;
    logic [4:0]   destination;
    logic [4:0]   destination2;
    circuit_sel_t circuit_sel;
  } id_ex_t;

  // Sign-extend the 5-bit immediate of format II.
  function automatic logic [31:0] sext_imm5(input logic [4:0] imm);
    return {{27{imm[4]}}, imm};
  endfunction

endpackage

// File: rtl/decorder_bcond_eval.sv
// Branch-condition evaluator: maps a 4-bit V850 condition code and the PSW
// flags to a taken/not-taken decision. Codes 8-F negate codes 0-7.
module bcond_eval
  import decorder_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic z, s, ov, cy;
  logic base;

  assign z  = flags[PSW_Z];
  assign s  = flags[PSW_S];
  assign ov = flags[PSW_OV];
  assign cy = flags[PSW_CY];

  // Evaluate the positive condition, then let cond[3] invert it.
  always_comb begin
    // NOTE: a default assignment before the case keeps every path assigned, so no latch is inferred.
    base = 1'b0;
    case (cond[2:0])
      3'd0: base = ov;
      3'd1: base = cy;
      3'd2: base = z;
      3'd3: base = cy | z;
      3'd4: base = s;
      3'd5: base = 1'b1;
      3'd6: base = s ^ ov;
      3'd7: base = (s ^ ov) | z;
      default: base = 1'b0;
    endcase
    taken = base ^ cond[3];
  end

endmodule

// File: rtl/decorder.sv
// V850 instruction-decode stage. Decodes formats I, II, III and VI from the
// instruction at ID, reads operands from the register file, and registers
// operands, destination, length flag and execute-unit select for EX.
module decorder
  import decorder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] instruction_ID_i,
  input  logic [24:0] PC_ID_i,
  input  logic [31:0] GR [32],
  input  logic [31:0] PSW_i,
  output logic [31:0] reg1_o,
  output logic [31:0] reg2_o,
  output logic [31:0] reg3_o,
  output logic        increment_bit_o,
  output logic [4:0]  destination_o,
  output logic [4:0]  destination2_o,
  output logic [9:0]  circuit_sel_o
);

  logic [15:0] h;
  logic [15:0] imm16;
  logic [4:0]  reg1_idx, reg2_idx;
  logic [5:0]  opcode;
  logic [31:0] gr_reg1, gr_reg2;
  logic        taken;
  logic [8:0]  disp9;
  logic [25:0] branch_target;

  circuit_sel_t sel;
  fmt_t         fmt;
  logic         writes_dest;
  logic         use_reg2;
  id_ex_t       nxt, q;

  // Upper instruction halfwords and PSW bits above CY are not used here.
  logic unused_bits;
  assign unused_bits = ^{instruction_ID_i[63:32], PSW_i[31:4]};

  assign h        = instruction_ID_i[15:0];
  assign imm16    = instruction_ID_i[31:16];
  assign reg2_idx = h[15:11];
  assign opcode   = h[10:5];
  assign reg1_idx = h[4:0];

  // r0 is hard-wired to zero whatever the register file holds.
  assign gr_reg1 = (reg1_idx == 5'd0) ? 32'd0 : GR[reg1_idx];
  assign gr_reg2 = (reg2_idx == 5'd0) ? 32'd0 : GR[reg2_idx];

  // Branch displacement is in bytes; the target wraps in the 26-bit space.
  assign disp9         = {h[15:11], h[6:4], 1'b0};
  assign branch_target = {PC_ID_i, 1'b0} + {{17{disp9[8]}}, disp9};

  bcond_eval u_bcond_eval (
    .cond  (h[3:0]),
    .flags (PSW_i[3:0]),
    .taken (taken)
  );

  // Classify the opcode: select code, operand format, destination use.
  always_comb begin
    sel         = SEL_NOP;
    fmt         = FMT_NONE;
    writes_dest = 1'b0;
    use_reg2    = 1'b0;
    if (opcode[5:2] == OP_BCOND_HI) begin
      if (taken) begin
        sel = SEL_BCOND_TAKEN;
        fmt = FMT_III;
      end
    end else begin
      case (opcode)
        OP_MOV_R: if (h != 16'd0) begin
          sel = SEL_MOV; fmt = FMT_I; writes_dest = 1'b1;
        end
        OP_OR_R:   begin sel = SEL_OR;   fmt = FMT_I; writes_dest = 1'b1; end
        OP_XOR_R:  begin sel = SEL_XOR;  fmt = FMT_I; writes_dest = 1'b1; end
        OP_AND_R:  begin sel = SEL_AND;  fmt = FMT_I; writes_dest = 1'b1; end
        OP_TST_R:  begin sel = SEL_TST;  fmt = FMT_I; end
        OP_SUBR_R: begin sel = SEL_SUBR; fmt = FMT_I; writes_dest = 1'b1; end
        OP_SUB_R:  begin sel = SEL_SUB;  fmt = FMT_I; writes_dest = 1'b1; end
        OP_ADD_R:  begin sel = SEL_ADD;  fmt = FMT_I; writes_dest = 1'b1; end
        OP_CMP_R:  begin sel = SEL_CMP;  fmt = FMT_I; end
        OP_MOV_I:  begin sel = SEL_MOV;  fmt = FMT_II; writes_dest = 1'b1; end
        OP_ADD_I:  begin sel = SEL_ADD;  fmt = FMT_II; writes_dest = 1'b1; use_reg2 = 1'b1; end
        OP_CMP_I:  begin sel = SEL_CMP;  fmt = FMT_II; use_reg2 = 1'b1; end
        OP_ADDI:   begin sel = SEL_ADD;  fmt = FMT_VI_S; writes_dest = 1'b1; end
        OP_MOVEA:  begin sel = SEL_ADD;  fmt = FMT_VI_S; writes_dest = 1'b1; end
        OP_ORI:    begin sel = SEL_OR;   fmt = FMT_VI_Z; writes_dest = 1'b1; end
        OP_XORI:   begin sel = SEL_XOR;  fmt = FMT_VI_Z; writes_dest = 1'b1; end
        OP_ANDI:   begin sel = SEL_AND;  fmt = FMT_VI_Z; writes_dest = 1'b1; end
        default: ;
      endcase
    end
  end

  // Route operands by format; anything a format does not use stays zero.
  always_comb begin
    nxt             = '0;
    nxt.circuit_sel = sel;
    nxt.destination = writes_dest ? reg2_idx : 5'd0;
    case (fmt)
      FMT_I: begin
        nxt.reg1 = gr_reg1;
        nxt.reg2 = gr_reg2;
      end
      FMT_II: begin
        nxt.reg1 = sext_imm5(reg1_idx);
        nxt.reg2 = use_reg2 ? gr_reg2 : 32'd0;
      end
      FMT_VI_S: begin
        nxt.reg1      = gr_reg1;
        nxt.reg3      = {{16{imm16[15]}}, imm16};
        nxt.increment = 1'b1;
      end
      FMT_VI_Z: begin
        nxt.reg1      = gr_reg1;
        nxt.reg3      = {16'd0, imm16};
        nxt.increment = 1'b1;
      end
      FMT_III: begin
        nxt.reg3 = {6'd0, branch_target};
      end
      default: ;
    endcase
  end

  // ID/EX pipeline register; reset clears it to a NOP immediately.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) q <= '0;
    else        q <= nxt;
  end

  assign reg1_o          = q.reg1;
  assign reg2_o          = q.reg2;
  assign reg3_o          = q.reg3;
  assign increment_bit_o = q.increment;
  assign destination_o   = q.destination;
  assign destination2_o  = q.destination2;
  assign circuit_sel_o   = q.circuit_sel;

endmodule

// File: tb/tb_decorder.sv
// Directed self-checking bench for the decorder ID stage.
module tb_decorder;

  logic        clk;
  logic        reset;
  logic [63:0] instruction_ID_i;
  logic [24:0] PC_ID_i;
  logic [31:0] gr [32];
  logic [31:0] PSW_i;
  logic [31:0] reg1_o, reg2_o, reg3_o;
  logic        increment_bit_o;
  logic [4:0]  destination_o, destination2_o;
  logic [9:0]  circuit_sel_o;

  int checks = 0;
  int errors = 0;

  decorder dut (
    .clk              (clk),
    .reset            (reset),
    .instruction_ID_i (instruction_ID_i),
    .PC_ID_i          (PC_ID_i),
    .GR               (gr),
    .PSW_i            (PSW_i),
    .reg1_o           (reg1_o),
    .reg2_o           (reg2_o),
    .reg3_o           (reg3_o),
    .increment_bit_o  (increment_bit_o),
    .destination_o    (destination_o),
    .destination2_o   (destination2_o),
    .circuit_sel_o    (circuit_sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction, clock it in, sample 1 time unit after the edge.
  task automatic step(input logic [63:0] instr);
    instruction_ID_i = instr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    instruction_ID_i = 64'h11C1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({reg1_o, reg2_o, reg3_o, increment_bit_o, destination_o, destination2_o, circuit_sel_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got r1=%h r2=%h r3=%h inc=%b d=%0d d2=%0d sel=%0d, need all 0",
               reg1_o, reg2_o, reg3_o, increment_bit_o, destination_o, destination2_o, circuit_sel_o);
    end
    reset = 1'b1;
    step(64'h11C1);
    checks++;
    if (circuit_sel_o !== 10'd1 || reg1_o !== 32'hA000_0001 || reg2_o !== 32'hA000_0002 ||
        destination_o !== 5'd2 || increment_bit_o !== 1'b0) begin
      errors++;
      $display("FAIL first_add got sel=%0d r1=%h r2=%h d=%0d inc=%b, need 1 A0000001 A0000002 2 0",
               circuit_sel_o, reg1_o, reg2_o, destination_o, increment_bit_o);
    end
  endtask

  task automatic test_format_i();
    step(64'h2141);  // AND r1,r4
    checks++;
    if (circuit_sel_o !== 10'd4 || destination_o !== 5'd4 || reg2_o !== 32'hA000_0004) begin
      errors++;
      $display("FAIL and_rr got sel=%0d d=%0d r2=%h, need 4 4 A0000004", circuit_sel_o, destination_o, reg2_o);
    end
    step(64'h49E1);  // CMP r1,r9
    checks++;
    if (circuit_sel_o !== 10'd7 || destination_o !== 5'd0 || reg2_o !== 32'hA000_0009 ||
        reg1_o !== 32'hA000_0001) begin
      errors++;
      $display("FAIL cmp_rr got sel=%0d d=%0d r1=%h r2=%h, need 7 0 A0000001 A0000009",
               circuit_sel_o, destination_o, reg1_o, reg2_o);
    end
    step(64'h1161);  // TST r1,r2
    checks++;
    if (circuit_sel_o !== 10'd8 || destination_o !== 5'd0) begin
      errors++;
      $display("FAIL tst_rr got sel=%0d d=%0d, need 8 0", circuit_sel_o, destination_o);
    end
    step(64'h2800);  // MOV r0,r5 : r0 reads as zero
    checks++;
    if (circuit_sel_o !== 10'd9 || reg1_o !== 32'd0 || destination_o !== 5'd5 || reg3_o !== 32'd0) begin
      errors++;
      $display("FAIL mov_r0 got sel=%0d r1=%h d=%0d r3=%h, need 9 0 5 0",
               circuit_sel_o, reg1_o, destination_o, reg3_o);
    end
    step(64'h1181);  // SUBR r1,r2
    checks++;
    if (circuit_sel_o !== 10'd3 || destination_o !== 5'd2) begin
      errors++;
      $display("FAIL subr_rr got sel=%0d d=%0d, need 3 2", circuit_sel_o, destination_o);
    end
  endtask

  task automatic test_format_ii();
    step(64'h125F);  // ADD -1,r2
    checks++;
    if (circuit_sel_o !== 10'd1 || reg1_o !== 32'hFFFF_FFFF || destination_o !== 5'd2 ||
        increment_bit_o !== 1'b0) begin
      errors++;
      $display("FAIL add_imm5 got sel=%0d r1=%h d=%0d inc=%b, need 1 FFFFFFFF 2 0",
               circuit_sel_o, reg1_o, destination_o, increment_bit_o);
    end
    step(64'h3A6F);  // CMP 15,r7
    checks++;
    if (circuit_sel_o !== 10'd7 || reg1_o !== 32'h0000_000F || destination_o !== 5'd0) begin
      errors++;
      $display("FAIL cmp_imm5 got sel=%0d r1=%h d=%0d, need 7 0000000F 0", circuit_sel_o, reg1_o, destination_o);
    end
  endtask

  task automatic test_format_vi();
    step({32'h0, 16'h000B, 16'h1EC1});  // ANDI 11,r1,r3
    checks++;
    if (circuit_sel_o !== 10'd4 || reg3_o !== 32'h0000_000B || destination_o !== 5'd3 ||
        increment_bit_o !== 1'b1 || reg1_o !== 32'hA000_0001) begin
      errors++;
      $display("FAIL andi got sel=%0d r3=%h d=%0d inc=%b r1=%h, need 4 0000000B 3 1 A0000001",
               circuit_sel_o, reg3_o, destination_o, increment_bit_o, reg1_o);
    end
    step({32'h0, 16'h8000, 16'h1E01});  // ADDI 0x8000,r1,r3
    checks++;
    if (circuit_sel_o !== 10'd1 || reg3_o !== 32'hFFFF_8000 || increment_bit_o !== 1'b1) begin
      errors++;
      $display("FAIL addi_sext got sel=%0d r3=%h inc=%b, need 1 FFFF8000 1", circuit_sel_o, reg3_o, increment_bit_o);
    end
    step({32'h0, 16'h8000, 16'h1E81});  // ORI 0x8000,r1,r3
    checks++;
    if (circuit_sel_o !== 10'd5 || reg3_o !== 32'h0000_8000 || destination_o !== 5'd3) begin
      errors++;
      $display("FAIL ori_zext got sel=%0d r3=%h d=%0d, need 5 00008000 3", circuit_sel_o, reg3_o, destination_o);
    end
    step({32'h0, 16'hFFFE, 16'h1E21});  // MOVEA -2,r1,r3
    checks++;
    if (circuit_sel_o !== 10'd1 || reg3_o !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL movea got sel=%0d r3=%h, need 1 FFFFFFFE", circuit_sel_o, reg3_o);
    end
  endtask

  task automatic test_bcond();
    PC_ID_i = 25'h100;
    PSW_i   = 32'h0;
    step(64'h05CA);  // BNZ +8, Z=0
    checks++;
    if (circuit_sel_o !== 10'd10 || reg3_o !== 32'h0000_0208 || destination_o !== 5'd0 ||
        increment_bit_o !== 1'b0) begin
      errors++;
      $display("FAIL bnz_taken got sel=%0d r3=%h d=%0d inc=%b, need 10 00000208 0 0",
               circuit_sel_o, reg3_o, destination_o, increment_bit_o);
    end
    PSW_i = 32'h1;
    step(64'h05CA);  // BNZ +8, Z=1
    checks++;
    if (circuit_sel_o !== 10'd0 || destination_o !== 5'd0) begin
      errors++;
      $display("FAIL bnz_not_taken got sel=%0d d=%0d, need 0 0", circuit_sel_o, destination_o);
    end
    step(64'hFDE5);  // BR -4 (always)
    checks++;
    if (circuit_sel_o !== 10'd10 || reg3_o !== 32'h0000_01FC) begin
      errors++;
      $display("FAIL br_back got sel=%0d r3=%h, need 10 000001FC", circuit_sel_o, reg3_o);
    end
    PSW_i = 32'h2;   // S=1, OV=0 -> S^OV true
    step(64'h05C6);  // BLT +8
    checks++;
    if (circuit_sel_o !== 10'd10) begin
      errors++;
      $display("FAIL blt_taken got sel=%0d, need 10", circuit_sel_o);
    end
    PSW_i = 32'h6;   // S=1, OV=1 -> S^OV false
    step(64'h05C6);
    checks++;
    if (circuit_sel_o !== 10'd0) begin
      errors++;
      $display("FAIL blt_not_taken got sel=%0d, need 0", circuit_sel_o);
    end
    PSW_i = 32'h0;
  endtask

  task automatic test_nop();
    step(64'h0);
    checks++;
    if ({reg1_o, reg2_o, reg3_o, increment_bit_o, destination_o, destination2_o, circuit_sel_o} !== '0) begin
      errors++;
      $display("FAIL nop_zero got r1=%h r2=%h r3=%h inc=%b d=%0d sel=%0d, need all 0",
               reg1_o, reg2_o, reg3_o, increment_bit_o, destination_o, circuit_sel_o);
    end
    step({32'h0, 16'h1234, 16'h07E0});
    checks++;
    if ({reg1_o, reg2_o, reg3_o, increment_bit_o, destination_o, destination2_o, circuit_sel_o} !== '0) begin
      errors++;
      $display("FAIL nop_undef got r1=%h r2=%h r3=%h inc=%b d=%0d sel=%0d, need all 0",
               reg1_o, reg2_o, reg3_o, increment_bit_o, destination_o, circuit_sel_o);
    end
  endtask

  task automatic test_back_to_back();
    step(64'h11A1);  // SUB r1,r2
    checks++;
    if (circuit_sel_o !== 10'd2 || destination_o !== 5'd2) begin
      errors++;
      $display("FAIL b2b_sub got sel=%0d d=%0d, need 2 2", circuit_sel_o, destination_o);
    end
    // New input between edges must not disturb the registered output.
    instruction_ID_i = 64'h2141;
    #3;
    checks++;
    if (circuit_sel_o !== 10'd2) begin
      errors++;
      $display("FAIL b2b_hold got sel=%0d, need 2", circuit_sel_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (circuit_sel_o !== 10'd4 || destination_o !== 5'd4) begin
      errors++;
      $display("FAIL b2b_and got sel=%0d d=%0d, need 4 4", circuit_sel_o, destination_o);
    end
  endtask

  task automatic test_reset_midstream();
    step(64'h11C1);
    reset = 1'b0;
    #1;
    checks++;
    if (circuit_sel_o !== 10'd0 || reg1_o !== 32'd0 || destination_o !== 5'd0) begin
      errors++;
      $display("FAIL async_reset got sel=%0d r1=%h d=%0d, need 0 0 0", circuit_sel_o, reg1_o, destination_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(64'h2141);
    checks++;
    if (circuit_sel_o !== 10'd4 || destination_o !== 5'd4) begin
      errors++;
      $display("FAIL after_reset got sel=%0d d=%0d, need 4 4", circuit_sel_o, destination_o);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gr[i] = 32'hA000_0000 | i;
    gr[0] = 32'hDEAD_BEEF;  // must never reach an operand
    PC_ID_i = 25'h0;
    PSW_i   = 32'h0;
    reset   = 1'b0;
    instruction_ID_i = 64'h0;
    #2;
    test_reset();
    test_format_i();
    test_format_ii();
    test_format_vi();
    test_bcond();
    test_nop();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
